// File: rtl/pcm_ctrl_pkg.sv
// Shared types and defaults for the PCM FIFO write-side controller.
package pcm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } burst_state_e;

  localparam int unsigned BURST_LEN_DEF = 64;
  localparam int unsigned CNT_W_DEF     = 8;

endpackage

// File: rtl/pcm_wr_hold.sv
// One-entry CPU hold register: absorbs unstallable CPU writes, drops them
// (sticky overflow) when the entry is blocked by a full FIFO.
module pcm_wr_hold
  import pcm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_cpu_wrdata,
  input  logic       i_cpu_write,
  input  logic       i_clear,
  input  logic       i_fifo_full,
  input  logic       i_fifo_reset,
  output logic       o_hold_valid,
  output logic [7:0] o_hold_data,
  output logic       o_drain,
  output logic       o_overflow
);

  logic       r_valid;
  logic [7:0] r_data;
  logic       r_overflow;
  logic       w_drain;

  assign w_drain = r_valid && !i_fifo_full && !i_fifo_reset;

  // Hold entry and sticky overflow; a clear request beats a same-cycle CPU write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_data     <= 8'h00;
      r_overflow <= 1'b0;
    end else if (i_clear) begin
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (i_cpu_write) begin
      if (r_valid && !w_drain) begin
        r_overflow <= 1'b1;
      end else begin
        r_valid <= 1'b1;
        r_data  <= i_cpu_wrdata;
      end
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_hold_valid = r_valid;
  assign o_hold_data  = r_data;
  assign o_drain      = w_drain;
  assign o_overflow   = r_overflow;

endmodule

// File: rtl/pcm_fifo_arbiter.sv
// Sole write-side controller of the PCM FIFO: arbitrates CPU hold vs refill
// stream, runs the refill burst FSM, sequences FIFO resets, raises AFLOW irq.
module pcm_fifo_arbiter
  import pcm_ctrl_pkg::*;
#(
  parameter int unsigned BURST_LEN = BURST_LEN_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cpu_wrdata,
  input  logic       cpu_write,
  input  logic       fifo_reset_req,
  input  logic       dma_en,
  input  logic       irq_en,
  output logic       dma_req,
  input  logic       dma_ack,
  input  logic [7:0] dma_data,
  input  logic       dma_valid,
  output logic       dma_ready,
  output logic       dma_abort,
  output logic [7:0] fifo_wrdata,
  output logic       fifo_write,
  output logic       fifo_reset,
  input  logic       fifo_full,
  input  logic       fifo_almost_empty,
  input  logic       fifo_empty,
  output logic       overflow,
  output logic       irq_aflow,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  burst_state_e     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_abort, w_abort_nxt;
  logic             r_fifo_reset;

  logic             w_hold_valid;
  logic [7:0]       w_hold_data;
  logic             w_hold_drain;
  logic             w_overflow;
  logic             w_dma_ready;
  logic             w_stream_xfer;
  logic             w_fifo_empty_unused;

  assign w_fifo_empty_unused = fifo_empty;

  pcm_wr_hold u_hold (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cpu_wrdata (cpu_wrdata),
    .i_cpu_write  (cpu_write),
    .i_clear      (fifo_reset_req),
    .i_fifo_full  (fifo_full),
    .i_fifo_reset (r_fifo_reset),
    .o_hold_valid (w_hold_valid),
    .o_hold_data  (w_hold_data),
    .o_drain      (w_hold_drain),
    .o_overflow   (w_overflow)
  );

  // The hold register always wins the write port, so the stream only moves when it is empty.
  assign w_dma_ready   = (r_state == ST_XFER) && !fifo_full && !w_hold_valid && !r_fifo_reset;
  assign w_stream_xfer = dma_valid && w_dma_ready;

  // Write-port grant mux.
  always_comb begin
    fifo_wrdata = 8'h00;
    if (w_hold_drain) begin
      fifo_wrdata = w_hold_data;
    end else if (w_stream_xfer) begin
      fifo_wrdata = dma_data;
    end else begin
      fifo_wrdata = 8'h00;
    end
  end

  assign fifo_write = (w_hold_drain || w_stream_xfer) && !r_fifo_reset;

  // Burst FSM next state; a reset request overrides everything and aborts a live burst.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_abort_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (dma_en && fifo_almost_empty && !r_fifo_reset) begin
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (!dma_en) begin
          w_state_nxt = ST_IDLE;
        end else if (dma_ack) begin
          w_state_nxt = ST_XFER;
          w_cnt_nxt   = CNT_LOAD;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_XFER: begin
        if (w_stream_xfer) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end else begin
          w_cnt_nxt = r_cnt;
        end
        if (!dma_en) begin
          w_state_nxt = ST_IDLE;
          w_abort_nxt = (w_cnt_nxt != CNT_ZERO);
          w_cnt_nxt   = CNT_ZERO;
        end else if (w_stream_xfer && (r_cnt == CNT_ONE)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_XFER;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
    if (fifo_reset_req) begin
      w_abort_nxt = (r_state == ST_XFER) && (w_cnt_nxt != CNT_ZERO);
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = CNT_ZERO;
    end else begin
      w_abort_nxt = w_abort_nxt;
    end
  end

  // Burst state, counter, abort pulse and FIFO reset pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= CNT_ZERO;
      r_abort      <= 1'b0;
      r_fifo_reset <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_abort      <= w_abort_nxt;
      r_fifo_reset <= fifo_reset_req;
    end
  end

  assign dma_req    = (r_state == ST_REQ);
  assign dma_ready  = w_dma_ready;
  assign dma_abort  = r_abort;
  assign fifo_reset = r_fifo_reset;
  assign overflow   = w_overflow;
  assign irq_aflow  = irq_en && fifo_almost_empty && !r_fifo_reset;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pcm_fifo_arbiter.sv
// Scoreboard bench for pcm_fifo_arbiter: expected FIFO bytes are queued by the
// stimulus, a negedge monitor pops and compares every FIFO write.
module tb_pcm_fifo_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cpu_wrdata;
  logic       cpu_write;
  logic       fifo_reset_req;
  logic       dma_en;
  logic       irq_en;
  logic       dma_req;
  logic       dma_ack;
  logic [7:0] dma_data = 8'h00;
  logic       dma_valid;
  logic       dma_ready;
  logic       dma_abort;
  logic [7:0] fifo_wrdata;
  logic       fifo_write;
  logic       fifo_reset;
  logic       fifo_full;
  logic       fifo_almost_empty;
  logic       fifo_empty;
  logic       overflow;
  logic       irq_aflow;
  logic       busy;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         wr_cnt = 0;
  int         req_cnt = 0;
  int         abort_cnt = 0;
  int         s_idx = 0;
  logic       prev_req = 1'b0;
  logic [7:0] exp_q[$];

  pcm_fifo_arbiter dut (
    .clk(clk), .rst_n(rst_n), .cpu_wrdata(cpu_wrdata), .cpu_write(cpu_write),
    .fifo_reset_req(fifo_reset_req), .dma_en(dma_en), .irq_en(irq_en),
    .dma_req(dma_req), .dma_ack(dma_ack), .dma_data(dma_data), .dma_valid(dma_valid),
    .dma_ready(dma_ready), .dma_abort(dma_abort), .fifo_wrdata(fifo_wrdata),
    .fifo_write(fifo_write), .fifo_reset(fifo_reset), .fifo_full(fifo_full),
    .fifo_almost_empty(fifo_almost_empty), .fifo_empty(fifo_empty),
    .overflow(overflow), .irq_aflow(irq_aflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every FIFO write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_write) begin
        wr_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: got 0x%0h expected no write", fifo_wrdata);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (fifo_wrdata !== e) begin
            n_bad++;
            $display("FAIL write_data: got 0x%0h expected 0x%0h", fifo_wrdata, e);
          end
        end
      end
      if (dma_req && !prev_req) req_cnt++;
      if (dma_abort) abort_cnt++;
      prev_req = dma_req;
    end
  end

  // Stream source: presents byte s_idx, advances after each accepted handshake.
  initial begin
    forever begin
      logic tx;
      @(posedge clk);
      tx = rst_n && dma_valid && dma_ready;
      #1;
      if (tx) begin
        s_idx++;
        dma_data = s_idx[7:0];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic start_burst(input string name);
    bit seen = 1'b0;
    fifo_almost_empty = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dma_req) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_req_seen"}, {31'd0, seen}, 32'd1);
    dma_ack = 1'b1;
    dma_valid = 1'b1;
    tick();
    dma_ack = 1'b0;
    fifo_almost_empty = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int base, input int exp_n);
    int prev_d = -1;
    bit done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      prev_d = wr_cnt - base;
      tick();
    end
    chk({name, "_done"}, {31'd0, done}, 32'd1);
    chk({name, "_writes"}, wr_cnt - base, exp_n);
    chk({name, "_busy_fall"}, prev_d, exp_n - 1);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; cpu_wrdata = 8'h00; cpu_write = 1'b0; fifo_reset_req = 1'b0;
    dma_en = 1'b0; irq_en = 1'b0; dma_ack = 1'b0; dma_valid = 1'b0;
    fifo_full = 1'b0; fifo_almost_empty = 1'b0; fifo_empty = 1'b1;
    #12;
    chk("reset_outputs",
        {16'd0, fifo_write, fifo_wrdata, dma_req, dma_ready, dma_abort, fifo_reset, overflow, irq_aflow, busy},
        32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: single CPU byte written exactly one cycle later
    cpu_wrdata = 8'h5A; cpu_write = 1'b1; exp_q.push_back(8'h5A);
    @(negedge clk);
    chk("t1_same_cycle", {31'd0, fifo_write}, 32'd0);
    tick();
    cpu_write = 1'b0;
    @(negedge clk);
    chk("t1_latency", {23'd0, fifo_write, fifo_wrdata}, {23'd0, 1'b1, 8'h5A});
    tick();
    chk("t1_overflow", {31'd0, overflow}, 32'd0);
    tick();

    // 2: second byte dropped while full, first written once on release
    fifo_full = 1'b1; base = wr_cnt;
    cpu_wrdata = 8'h11; cpu_write = 1'b1; exp_q.push_back(8'h11);
    tick();
    cpu_wrdata = 8'h22;
    tick();
    cpu_write = 1'b0;
    chk("t2_overflow", {31'd0, overflow}, 32'd1);
    tick(); tick();
    chk("t2_no_write_full", wr_cnt - base, 32'd0);
    fifo_full = 1'b0;
    tick(); tick(); tick();
    chk("t2_written_once", wr_cnt - base, 32'd1);
    chk("t2_queue_empty", exp_q.size(), 32'd0);

    // 3: full 64-byte burst
    dma_en = 1'b1;
    for (int i = 0; i < 64; i++) exp_q.push_back(8'(i));
    base = wr_cnt;
    start_burst("t3");
    wait_idle("t3", base, 64);
    dma_valid = 1'b0;
    tick(); tick();
    chk("t3_req_once", req_cnt, 32'd1);

    // 4: CPU byte interleaved after 10 stream bytes
    for (int i = 64; i < 74; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h80);
    for (int i = 74; i < 128; i++) exp_q.push_back(8'(i));
    base = wr_cnt;
    start_burst("t4");
    for (int i = 0; i < 9; i++) tick();
    cpu_wrdata = 8'h80; cpu_write = 1'b1;
    tick();
    cpu_write = 1'b0;
    @(negedge clk);
    chk("t4_stall", {31'd0, dma_ready}, 32'd0);
    #1;
    wait_idle("t4", base, 65);
    dma_valid = 1'b0;
    tick();
    chk("t4_queue_empty", exp_q.size(), 32'd0);

    // 5: FIFO reset during XFER with the hold register full
    exp_q.push_back(8'd128); exp_q.push_back(8'd129);
    start_burst("t5");
    tick();
    cpu_wrdata = 8'h99; cpu_write = 1'b1;
    tick();
    fifo_full = 1'b1; cpu_wrdata = 8'h44; fifo_reset_req = 1'b1;
    tick();
    fifo_reset_req = 1'b0; fifo_full = 1'b0; dma_valid = 1'b0;
    cpu_wrdata = 8'h33; exp_q.push_back(8'h33);
    @(negedge clk);
    chk("t5_state",
        {26'd0, fifo_reset, dma_abort, overflow, busy, fifo_write, dma_req},
        {26'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    tick();
    cpu_write = 1'b0;
    @(negedge clk);
    chk("t5_after", {29'd0, fifo_reset, dma_abort, fifo_write}, {29'd0, 1'b0, 1'b0, 1'b1});
    tick(); tick();
    chk("t5_queue_empty", exp_q.size(), 32'd0);
    chk("t5_abort_once", abort_cnt, 32'd1);

    // 6: AFLOW irq follows almost_empty, masked in the reset cycle
    dma_en = 1'b0; irq_en = 1'b1; fifo_almost_empty = 1'b1;
    tick();
    chk("t6_irq_on", {31'd0, irq_aflow}, 32'd1);
    fifo_almost_empty = 1'b0;
    tick();
    chk("t6_irq_off", {31'd0, irq_aflow}, 32'd0);
    fifo_almost_empty = 1'b1; fifo_reset_req = 1'b1;
    tick();
    fifo_reset_req = 1'b0;
    chk("t6_irq_masked", {31'd0, irq_aflow}, 32'd0);
    tick();
    chk("t6_irq_back", {31'd0, irq_aflow}, 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
